// File: rtl/maq_h_if.sv
// maq_h_if: run/set-mode inputs and hour/display outputs of the hours machine.
// The master side drives the carry, mode and button levels; the slave side is maq_h.
interface maq_h_if;
    logic       maqh_enable;
    logic       maqh_incremento;
    logic       maqh_ajuste_mais;
    logic       maqh_ajuste_menos;
    logic       maqh_modo12;
    logic [3:0] maqh_lsd;
    logic [1:0] maqh_msd;
    logic       maqh_incrementadia;
    logic [3:0] maqh_disp_lsd;
    logic [1:0] maqh_disp_msd;
    logic       maqh_pm;

    modport master (
        output maqh_enable, maqh_incremento, maqh_ajuste_mais, maqh_ajuste_menos, maqh_modo12,
        input  maqh_lsd, maqh_msd, maqh_incrementadia, maqh_disp_lsd, maqh_disp_msd, maqh_pm
    );

    modport slave (
        input  maqh_enable, maqh_incremento, maqh_ajuste_mais, maqh_ajuste_menos, maqh_modo12,
        output maqh_lsd, maqh_msd, maqh_incrementadia, maqh_disp_lsd, maqh_disp_msd, maqh_pm
    );
endinterface

// File: rtl/maq_h.sv
// maq_h: BCD hours counter 00..23 for the clock.
// Run mode counts carry pulses from the minutes machine and pulses the day
// rollover; set mode steps the hours with two buttons and auto-repeat.
// Optional 12-hour display conversion is built when MAQH_FORMATO12_EN is defined.
module maq_h #(
    parameter int REPEAT_CICLOS = 25_000_000
) (
    input  logic   maqh_clock,
    input  logic   maqh_reset,
    maq_h_if.slave bus
);
    localparam int               CNT_W    = $clog2(REPEAT_CICLOS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_CICLOS - 1);

    typedef enum logic [1:0] {CONTA, AJUSTE, REPETE} state_t;

    // Next BCD hour going up, wrapping 23 -> 00; result is {msd, lsd}.
    function automatic logic [5:0] hour_up(input logic [1:0] msd, input logic [3:0] lsd);
        logic [5:0] r;
        if (msd == 2'd2 && lsd == 4'd3)
            r = 6'd0;
        else if (lsd == 4'd9)
            r = {msd + 2'd1, 4'd0};
        else
            r = {msd, lsd + 4'd1};
        return r;
    endfunction

    // Next BCD hour going down, wrapping 00 -> 23; result is {msd, lsd}.
    function automatic logic [5:0] hour_down(input logic [1:0] msd, input logic [3:0] lsd);
        logic [5:0] r;
        if (msd == 2'd0 && lsd == 4'd0)
            r = {2'd2, 4'd3};
        else if (lsd == 4'd0)
            r = {msd - 2'd1, 4'd9};
        else
            r = {msd, lsd - 4'd1};
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       lsd_q, lsd_d;
    logic [1:0]       msd_q, msd_d;
    logic             dia_q, dia_d;
    logic             mais_h_q, mais_h_d;
    logic             menos_h_q, menos_h_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             up_q, up_d;

    logic press_mais, press_menos, held, step_up, step_dn;

    // Next-state logic: carry counting in run mode, button FSM in set mode.
    always_comb begin
        state_d     = state_q;
        lsd_d       = lsd_q;
        msd_d       = msd_q;
        dia_d       = 1'b0;
        cnt_d       = cnt_q;
        up_d        = up_q;
        mais_h_d    = bus.maqh_ajuste_mais;
        menos_h_d   = bus.maqh_ajuste_menos;
        press_mais  = bus.maqh_ajuste_mais & ~mais_h_q;
        press_menos = bus.maqh_ajuste_menos & ~menos_h_q;
        held        = up_q ? (bus.maqh_ajuste_mais & ~bus.maqh_ajuste_menos)
                           : (bus.maqh_ajuste_menos & ~bus.maqh_ajuste_mais);
        step_up     = 1'b0;
        step_dn     = 1'b0;

        if (bus.maqh_enable) begin
            // Run mode acts on this edge; any repeat in progress is abandoned.
            state_d = CONTA;
            if (bus.maqh_incremento) begin
                {msd_d, lsd_d} = hour_up(msd_q, lsd_q);
                dia_d          = (msd_q == 2'd2) && (lsd_q == 4'd3);
            end
        end else begin
            case (state_q)
                CONTA: state_d = AJUSTE;
                AJUSTE: begin
                    // Simultaneous presses cancel each other out.
                    if (press_mais ^ press_menos) begin
                        step_up = press_mais;
                        step_dn = press_menos;
                        up_d    = press_mais;
                        cnt_d   = '0;
                        state_d = REPETE;
                    end
                end
                REPETE: begin
                    if (!held) begin
                        state_d = AJUSTE;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        step_up = up_q;
                        step_dn = ~up_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = CONTA;
            endcase

            if (step_up)
                {msd_d, lsd_d} = hour_up(msd_q, lsd_q);
            else if (step_dn)
                {msd_d, lsd_d} = hour_down(msd_q, lsd_q);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            state_q   <= CONTA;
            lsd_q     <= 4'd0;
            msd_q     <= 2'd0;
            dia_q     <= 1'b0;
            mais_h_q  <= 1'b0;
            menos_h_q <= 1'b0;
            cnt_q     <= '0;
            up_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lsd_q     <= lsd_d;
            msd_q     <= msd_d;
            dia_q     <= dia_d;
            mais_h_q  <= mais_h_d;
            menos_h_q <= menos_h_d;
            cnt_q     <= cnt_d;
            up_q      <= up_d;
        end
    end

    assign bus.maqh_lsd           = lsd_q;
    assign bus.maqh_msd           = msd_q;
    assign bus.maqh_incrementadia = dia_q;

`ifdef MAQH_FORMATO12_EN
    logic [4:0] h24;
    logic [4:0] h12;

    assign h24 = (5'(msd_q) * 5'd10) + 5'(lsd_q);

    // Display conversion: 12-hour format with PM flag, or 24-hour passthrough.
    always_comb begin
        bus.maqh_disp_lsd = lsd_q;
        bus.maqh_disp_msd = msd_q;
        bus.maqh_pm       = (h24 >= 5'd12);
        h12               = h24;
        if (bus.maqh_modo12) begin
            if (h24 == 5'd0)
                h12 = 5'd12;
            else if (h24 > 5'd12)
                h12 = h24 - 5'd12;
            if (h12 >= 5'd10) begin
                bus.maqh_disp_msd = 2'd1;
                bus.maqh_disp_lsd = 4'(h12 - 5'd10);
            end else begin
                bus.maqh_disp_msd = 2'd0;
                bus.maqh_disp_lsd = 4'(h12);
            end
        end
    end
`else
    logic unused_modo12;

    assign unused_modo12     = bus.maqh_modo12;
    assign bus.maqh_disp_lsd = lsd_q;
    assign bus.maqh_disp_msd = msd_q;
    assign bus.maqh_pm       = 1'b0;
`endif
endmodule

// File: tb/tb_maq_h.sv
// tb_maq_h: directed test of the hours machine with REPEAT_CICLOS = 4.
module tb_maq_h;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    maq_h_if bus ();

    maq_h #(.REPEAT_CICLOS(4)) dut (
        .maqh_clock (clk),
        .maqh_reset (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic check_h(input string tag, input int h, input bit dia);
        check({tag, "_msd"}, {6'd0, bus.maqh_msd}, 8'(h / 10));
        check({tag, "_lsd"}, {4'd0, bus.maqh_lsd}, 8'(h % 10));
        check({tag, "_dia"}, {7'd0, bus.maqh_incrementadia}, {7'd0, dia});
    endtask

    task automatic check_disp(input string tag, input int m, input int l, input bit pm);
        check({tag, "_dmsd"}, {6'd0, bus.maqh_disp_msd}, 8'(m));
        check({tag, "_dlsd"}, {4'd0, bus.maqh_disp_lsd}, 8'(l));
        check({tag, "_pm"}, {7'd0, bus.maqh_pm}, {7'd0, pm});
    endtask

    task automatic pulse();
        bus.maqh_incremento = 1'b1;
        tick();
        bus.maqh_incremento = 1'b0;
        tick();
    endtask

    task automatic press(input bit up);
        if (up) bus.maqh_ajuste_mais = 1'b1;
        else    bus.maqh_ajuste_menos = 1'b1;
        tick();
        bus.maqh_ajuste_mais  = 1'b0;
        bus.maqh_ajuste_menos = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass                = 0;
        n_total               = 0;
        rst_n                 = 1'b0;
        bus.maqh_enable       = 1'b1;
        bus.maqh_incremento   = 1'b0;
        bus.maqh_ajuste_mais  = 1'b0;
        bus.maqh_ajuste_menos = 1'b0;
        bus.maqh_modo12       = 1'b0;

        // Reset state
        #12;
        check_h("rst_hold", 0, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check_h("post_rst", 0, 1'b0);

        // Carry counting through a full day
        for (int i = 1; i <= 24; i++) begin
            bus.maqh_incremento = 1'b1;
            tick();
            bus.maqh_incremento = 1'b0;
            check_h($sformatf("cnt%0d", i), i % 24, i == 24);
        end
        tick();
        check_h("cnt_after_wrap", 0, 1'b0);

        // Asynchronous reset mid-count at 17
        for (int i = 0; i < 17; i++) pulse();
        check_h("pre_rst17", 17, 1'b0);
        #2 rst_n = 1'b0;
        #1 check_h("async_rst17", 0, 1'b0);
        #3 rst_n = 1'b1;
        tick();
        tick();
        check_h("rst_idle", 0, 1'b0);

        // Set-mode single steps with wrap
        for (int i = 0; i < 23; i++) pulse();
        check_h("at23", 23, 1'b0);
        bus.maqh_enable = 1'b0;
        tick();
        bus.maqh_ajuste_mais = 1'b1;
        tick();
        check_h("set_up_wrap", 0, 1'b0);
        bus.maqh_ajuste_mais = 1'b0;
        tick();
        check_h("set_release", 0, 1'b0);
        bus.maqh_ajuste_menos = 1'b1;
        tick();
        check_h("set_dn_wrap", 23, 1'b0);
        bus.maqh_ajuste_menos = 1'b0;
        tick();

        // Auto-repeat from 05
        for (int i = 0; i < 6; i++) press(1'b1);
        check_h("at05", 5, 1'b0);
        bus.maqh_ajuste_mais = 1'b1;
        for (int k = 0; k < 13; k++) begin
            tick();
            check_h($sformatf("rep%0d", k), 5 + k / 4 + 1, 1'b0);
        end
        bus.maqh_ajuste_mais = 1'b0;
        tick();
        check_h("rep_release", 9, 1'b0);

        // Both buttons together
        bus.maqh_ajuste_mais  = 1'b1;
        bus.maqh_ajuste_menos = 1'b1;
        tick();
        check_h("both_press", 9, 1'b0);
        tick();
        tick();
        check_h("both_held", 9, 1'b0);
        bus.maqh_ajuste_mais  = 1'b0;
        bus.maqh_ajuste_menos = 1'b0;
        tick();

        // Carry dropped in set mode
        bus.maqh_incremento = 1'b1;
        tick();
        bus.maqh_incremento = 1'b0;
        check_h("carry_dropped", 9, 1'b0);
        tick();
        check_h("carry_not_queued", 9, 1'b0);

        // Enable rises exactly where the next repeat step would land
        bus.maqh_ajuste_mais = 1'b1;
        tick();
        check_h("rep2_first", 10, 1'b0);
        tick();
        tick();
        tick();
        bus.maqh_enable = 1'b1;
        tick();
        check_h("enable_abort", 10, 1'b0);
        tick();
        tick();
        tick();
        tick();
        check_h("enable_held_run", 10, 1'b0);

        // Button already held when set mode is entered
        bus.maqh_enable = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_h("held_on_entry", 10, 1'b0);
        bus.maqh_ajuste_mais = 1'b0;
        tick();
        bus.maqh_ajuste_mais = 1'b1;
        tick();
        check_h("repress", 11, 1'b0);
        bus.maqh_ajuste_mais = 1'b0;
        tick();

        // Display format
        bus.maqh_modo12 = 1'b1;
        press(1'b1);
        check_h("at12", 12, 1'b0);
`ifdef MAQH_FORMATO12_EN
        check_disp("d12", 1, 2, 1'b1);
`else
        check_disp("d12", 1, 2, 1'b0);
`endif
        press(1'b1);
        check_h("at13", 13, 1'b0);
`ifdef MAQH_FORMATO12_EN
        check_disp("d13", 0, 1, 1'b1);
`else
        check_disp("d13", 1, 3, 1'b0);
`endif
        for (int i = 0; i < 13; i++) press(1'b0);
        check_h("at00", 0, 1'b0);
`ifdef MAQH_FORMATO12_EN
        check_disp("d00", 1, 2, 1'b0);
`else
        check_disp("d00", 0, 0, 1'b0);
`endif
        bus.maqh_modo12 = 1'b0;

        // Reset during the day-rollover pulse
        bus.maqh_enable = 1'b1;
        tick();
        for (int i = 0; i < 23; i++) pulse();
        check_h("at23_run", 23, 1'b0);
        bus.maqh_incremento = 1'b1;
        tick();
        bus.maqh_incremento = 1'b0;
        check_h("wrap_pulse", 0, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_h("rst_in_pulse", 0, 1'b0);
        #3 rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
